// File: rtl/regfile_wb_arbiter.sv
// Write-port owner for the 32-entry register file: clears x1..x(N-1) after reset,
// then round-robin arbitrates two write-back sources onto one registered write port.
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [XLEN-1:0]   a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [XLEN-1:0]   b_data,
  output logic              init_done,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_reg_addr,
  output logic [XLEN-1:0]   rf_write_data,
  output logic              dbg_state
);

  // Handshake: a write transfers on a rising edge where valid && ready. ready is
  // combinational, at most one source is ready per cycle, and a source keeps
  // valid/addr/data stable until it sees ready.

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // The pointer is one bit wider than an address so "all registers issued"
  // is a distinct value, independent of NUM_REGS being a power of two.
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] PTR_END = (ADDR_W+1)'(NUM_REGS);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   clr_ptr_q, clr_ptr_d;
  logic              last_grant_q, last_grant_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [XLEN-1:0]   rf_data_q, rf_data_d;
  logic              init_done_q, init_done_d;
  logic              grant_a, grant_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      clr_ptr_q    <= PTR_ONE;
      last_grant_q <= SRC_B;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      init_done_q  <= init_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    init_done_d  = init_done_q;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (clr_ptr_q == PTR_END) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          rf_we_d   = 1'b1;
          rf_addr_d = clr_ptr_q[ADDR_W-1:0];
          rf_data_d = '0;
          clr_ptr_d = clr_ptr_q + PTR_ONE;
        end
      end
      ST_RUN: begin
        // On a tie the source that did not win last time goes first.
        grant_a = a_valid && (!b_valid || (last_grant_q == SRC_B));
        grant_b = b_valid && !grant_a;
        if (grant_a) begin
          rf_we_d      = (a_addr != '0);
          rf_addr_d    = a_addr;
          rf_data_d    = a_data;
          last_grant_d = SRC_A;
        end else if (grant_b) begin
          rf_we_d      = (b_addr != '0);
          rf_addr_d    = b_addr;
          rf_data_d    = b_data;
          last_grant_d = SRC_B;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign a_ready           = grant_a;
  assign b_ready           = grant_b;
  assign init_done         = init_done_q;
  assign rf_write_enable   = rf_we_q;
  assign rf_write_reg_addr = rf_addr_q;
  assign rf_write_data     = rf_data_q;
  assign dbg_state         = (state_q == ST_RUN);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes queued by the driver,
// popped and compared by a monitor whenever the write port fires.
module tb_regfile_wb_arbiter;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [XLEN-1:0]   a_data, b_data;
  logic              init_done;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_write_reg_addr;
  logic [XLEN-1:0]   rf_write_data;
  logic              dbg_state;

  logic [ADDR_W+XLEN-1:0] exp_q[$];
  logic [XLEN-1:0]        rf_model[32];
  int n_checks;
  int n_fail;

  regfile_wb_arbiter #(.XLEN(XLEN), .NUM_REGS(32), .ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .a_valid           (a_valid),
    .a_ready           (a_ready),
    .a_addr            (a_addr),
    .a_data            (a_data),
    .b_valid           (b_valid),
    .b_ready           (b_ready),
    .b_addr            (b_addr),
    .b_data            (b_data),
    .init_done         (init_done),
    .rf_write_enable   (rf_write_enable),
    .rf_write_reg_addr (rf_write_reg_addr),
    .rf_write_data     (rf_write_data),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // RegisterFile stand-in: commits whatever the port presents; x0 stays zero.
  always @(posedge clk) begin
    if (rf_write_enable && rf_write_reg_addr != '0)
      rf_model[rf_write_reg_addr] <= rf_write_data;
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && rf_write_enable) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                 rf_write_reg_addr, rf_write_data);
      end else begin
        logic [ADDR_W+XLEN-1:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", XLEN'(rf_write_reg_addr), XLEN'(e[ADDR_W+XLEN-1:XLEN]));
        chk("wr_data", rf_write_data, e[XLEN-1:0]);
      end
    end
  end

  // driver tasks
  task automatic cycle(input logic av, input logic [ADDR_W-1:0] aa, input logic [XLEN-1:0] ad,
                       input logic bv, input logic [ADDR_W-1:0] ba, input logic [XLEN-1:0] bd,
                       input logic exp_ar, input logic exp_br);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    @(negedge clk);
    chk("a_ready", XLEN'(a_ready), XLEN'(exp_ar));
    chk("b_ready", XLEN'(b_ready), XLEN'(exp_br));
    if (exp_ar && aa != '0) exp_q.push_back({aa, ad});
    if (exp_br && ba != '0) exp_q.push_back({ba, bd});
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", XLEN'({a_ready, b_ready}), '0);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", XLEN'(rf_write_enable), '0);
    chk("rst_addr", XLEN'(rf_write_reg_addr), '0);
    chk("rst_data", rf_write_data, '0);
    chk("rst_init_done", XLEN'(init_done), '0);
    chk("rst_ready", XLEN'({a_ready, b_ready}), '0);
  endtask

  // Releases reset and follows the clear sweep; abort_at>0 re-asserts reset after that edge.
  task automatic run_sweep(input int abort_at);
    exp_q.delete();
    for (int k = 1; k <= 31; k++) begin
      logic [ADDR_W-1:0] ka;
      ka = k[ADDR_W-1:0];
      exp_q.push_back({ka, 32'h0});
    end
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hBAD0_0009;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hBAD0_000A;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_we", XLEN'(rf_write_enable), '0);
        chk("abort_addr", XLEN'(rf_write_reg_addr), '0);
        chk("abort_init_done", XLEN'(init_done), '0);
        exp_q.delete();
        a_valid = 1'b0;
        b_valid = 1'b0;
        return;
      end
      if (k < 32) begin
        chk("sweep_init_done", XLEN'(init_done), '0);
        chk("sweep_ready", XLEN'({a_ready, b_ready}), '0);
      end else begin
        chk("sweep_done", XLEN'(init_done), 32'd1);
        chk("sweep_end_we", XLEN'(rf_write_enable), '0);
        a_valid = 1'b0;
        b_valid = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 32; i++) rf_model[i] = 32'hA5A5_0000 | i;
    rf_model[0] = '0;
    rst_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;

    // 1: reset and full clear sweep
    apply_reset();
    run_sweep(0);
    chk("swept_x1", rf_model[1], '0);
    chk("swept_x7", rf_model[7], '0);
    chk("swept_x31", rf_model[31], '0);

    // 2: only A
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    idle_cycle();
    chk("x5_after_a", rf_model[5], 32'hDEADBEEF);

    // 3: both valid continuously; last grant was A so B leads
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1);
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0);
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1);
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0);
    idle_cycle();
    chk("x3_alt", rf_model[3], 32'h33);
    chk("x4_alt", rf_model[4], 32'h44);

    // 4: write to x0 accepted but dropped; it still counts as an A grant
    cycle(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("x0_drop_we", XLEN'(rf_write_enable), '0);

    // 6: ties, held source, same-address ordering
    cycle(1'b1, 5'd3, 32'h55, 1'b1, 5'd8, 32'hB8, 1'b0, 1'b1);
    cycle(1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 32'h67, 1'b1, 1'b0);
    cycle(1'b1, 5'd8, 32'hA8, 1'b1, 5'd3, 32'h67, 1'b0, 1'b1);
    cycle(1'b1, 5'd8, 32'hA8, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    idle_cycle();
    chk("x0_zero", rf_model[0], '0);
    chk("x3_later_wins", rf_model[3], 32'h67);
    chk("x8_a_last", rf_model[8], 32'hA8);
    chk("hold_addr", XLEN'(rf_write_reg_addr), 32'd8);
    chk("hold_data", rf_write_data, 32'hA8);

    // 5: preload x7, reset mid-write, reset mid-sweep, full re-sweep
    cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    idle_cycle();
    chk("x7_preload", rf_model[7], 32'h77);
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    @(negedge clk);
    chk("midrun_a_ready", XLEN'(a_ready), 32'd1);
    @(posedge clk); #1;
    chk("midrun_we", XLEN'(rf_write_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_we", XLEN'(rf_write_enable), '0);
    chk("midrun_rst_data", rf_write_data, '0);
    apply_reset();
    run_sweep(10);
    apply_reset();
    run_sweep(0);
    chk("x7_cleared", rf_model[7], '0);
    chk("x9_discarded", rf_model[9], '0);

    // last grant returns to B on reset, so the first tie goes to A
    cycle(1'b1, 5'd6, 32'h61, 1'b1, 5'd6, 32'h62, 1'b1, 1'b0);
    cycle(1'b0, 5'd6, 32'h61, 1'b1, 5'd6, 32'h62, 1'b0, 1'b1);
    idle_cycle();
    chk("x6_b_last", rf_model[6], 32'h62);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", XLEN'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
